// File: rtl/spi_minion_adapter.sv
// Sequencing/arbitration adapter between the SPI minion parallel port and device-side val/rdy streams.
// Optional drop counter enabled by defining SPI_MINION_ADAPTER_STATS_EN.
module spi_minion_adapter #(
  parameter int PACK_SIZE = 32,
  parameter int NUM_REQ   = 2,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            serve,
  input  logic                            seize,
  input  logic [PACK_SIZE-1:0]            to_device,
  output logic [PACK_SIZE-1:0]            from_device,
  output logic [PACK_SIZE-3:0]            recv_msg,
  output logic                            recv_val,
  input  logic                            recv_rdy,
  input  logic [NUM_REQ*(PACK_SIZE-2)-1:0] send_msg,
  input  logic [NUM_REQ-1:0]              send_val,
  output logic [NUM_REQ-1:0]              send_rdy
`ifdef SPI_MINION_ADAPTER_STATS_EN
  ,
  output logic [15:0]                     drop_count
`endif
);

  localparam int PW    = PACK_SIZE - 2;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
  localparam logic [RR_W:0]    NUM_REQ_W   = (RR_W+1)'(NUM_REQ);
  localparam logic [RR_W-1:0]  LAST_REQ    = RR_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------------
  // TX FIFO state
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_CW-1:0] tx_cnt;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;
  logic [PW-1:0]    tx_wdata;

  // ---------------------------------------------------------------------------
  // RX FIFO state
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_CW-1:0] rx_cnt;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_pkt_val;

  // ---------------------------------------------------------------------------
  // Arbiter state
  // ---------------------------------------------------------------------------
  logic [RR_W-1:0]  rr;
  logic [RR_W-1:0]  gnt_idx;
  logic             gnt_found;

  // The spc flag from the master is informational only; nothing gates on it.
  logic             unused_spc;
  assign unused_spc = to_device[PACK_SIZE-2];

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_FULL_CNT);

  // Round-robin search starting at rr, wrapping at NUM_REQ.
  always_comb begin
    logic [RR_W:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr} + (RR_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!gnt_found && send_val[cand[RR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[RR_W-1:0];
      end
    end
  end

  // Full is taken from registered occupancy, so a same-cycle pop never frees a slot early.
  always_comb begin
    send_rdy = '0;
    if (gnt_found && !tx_full) send_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    tx_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == RR_W'(i)) tx_wdata = send_msg[i*PW +: PW];
    end
  end

  assign tx_push    = |(send_val & send_rdy);
  assign tx_pop     = seize & ~tx_empty;

  assign rx_pkt_val = serve & to_device[PACK_SIZE-1];
  assign rx_pop     = recv_rdy & ~rx_empty;
  assign rx_push    = rx_pkt_val & (~rx_full | rx_pop);

  // ---------------------------------------------------------------------------
  // Outputs are driven from registered state only, so they are stable at seize.
  // ---------------------------------------------------------------------------
  assign from_device = {~tx_empty, ~rx_full, tx_empty ? {PW{1'b0}} : tx_mem[tx_rd_ptr]};
  assign recv_val    = ~rx_empty;
  assign recv_msg    = rx_empty ? {PW{1'b0}} : rx_mem[rx_rd_ptr];

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      rr        <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
        rr        <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + RR_W'(1);
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + TX_CW'(1);
        2'b01:   tx_cnt <= tx_cnt - TX_CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + RX_CW'(1);
        2'b01:   rx_cnt <= rx_cnt - RX_CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; reads are masked by the empty flags, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_wdata;
    if (rx_push) rx_mem[rx_wr_ptr] <= to_device[PW-1:0];
  end

`ifdef SPI_MINION_ADAPTER_STATS_EN
  logic rx_drop;
  assign rx_drop = rx_pkt_val & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (rx_drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
